// File: rtl/router_pkg.sv
// Shared flit and FSM encodings for the router input-port request controller.
package router_pkg;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    TAIL   = 2'b01,
    HEAD   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  // The type field occupies the top TYPE_W bits of every flit.
  localparam int TYPE_W = 2;

endpackage

// File: rtl/dest_dec.sv
// Destination-to-one-hot decoder with an out-of-range flag for non power-of-2 port counts.
module dest_dec #(
  parameter int NPORT = 4
) (
  input  logic [$clog2(NPORT)-1:0] dest,
  output logic [NPORT-1:0]         onehot,
  output logic                     oor
);

  localparam int DEST_W = $clog2(NPORT);

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_dec
    assign onehot[gi] = (dest == DEST_W'(gi));
  end

  // Extra bit so the compare also works when NPORT is a power of 2.
  assign oor = ({1'b0, dest} >= (DEST_W + 1)'(NPORT));

endmodule

// File: rtl/req_ctl.sv
// Input-port request controller: holds a one-hot output request for a whole packet
// and forwards its flits through a single output register.
module req_ctl
  import router_pkg::*;
#(
  parameter int NPORT  = 4,
  parameter int FLIT_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [NPORT-1:0]  reqi,
  input  logic [NPORT-1:0]  gnt,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_vld,
  input  logic              out_rdy,
  input  logic              err_clr,
  output logic              err
);

  localparam int DEST_W = $clog2(NPORT);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_XFER = XFER;

  logic [1:0]        state_reg;
  logic              last_reg;
  logic [FLIT_W-1:0] head_reg;
  logic [FLIT_W-1:0] out_flit_reg;
  logic              out_vld_reg;
  logic [NPORT-1:0]  reqi_reg;
  logic              err_reg;

  logic [1:0]        in_type;
  logic              is_hdr;
  logic [NPORT-1:0]  dec_onehot;
  logic              dec_oor;
  logic              acc;
  logic              drain;
  logic              granted;
  logic              err_set;

  assign in_type = in_flit[FLIT_W-1 -: TYPE_W];
  assign is_hdr  = in_type[1];  // head or single

  dest_dec #(
    .NPORT(NPORT)
  ) u_dest_dec (
    .dest  (in_flit[DEST_W-1:0]),
    .onehot(dec_onehot),
    .oor   (dec_oor)
  );

  always_comb begin
    in_rdy = 1'b0;
    case (state_reg)
      ST_IDLE: in_rdy = 1'b1;
      ST_XFER: in_rdy = !last_reg && (!out_vld_reg || out_rdy);
      default: in_rdy = 1'b0;
    endcase
  end

  assign acc     = in_vld && in_rdy;
  assign drain   = out_vld_reg && out_rdy;
  assign granted = |(gnt & reqi_reg);
  assign err_set = acc && (((state_reg == ST_IDLE) && (!is_hdr || dec_oor)) ||
                           ((state_reg == ST_XFER) && is_hdr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      last_reg     <= 1'b0;
      head_reg     <= '0;
      out_flit_reg <= '0;
      out_vld_reg  <= 1'b0;
      reqi_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= err_set | (err_reg & ~err_clr);
      case (state_reg)
        ST_IDLE: begin
          if (acc && is_hdr && !dec_oor) begin
            head_reg  <= in_flit;
            last_reg  <= (in_type == SINGLE);
            reqi_reg  <= dec_onehot;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (granted) begin
            out_flit_reg <= head_reg;
            out_vld_reg  <= 1'b1;
            state_reg    <= ST_XFER;
          end
        end
        ST_XFER: begin
          // in_rdy is low once last is set, so the final drain never races a new load.
          if (last_reg && drain) begin
            out_vld_reg <= 1'b0;
            reqi_reg    <= '0;
            last_reg    <= 1'b0;
            state_reg   <= ST_IDLE;
          end else if (acc && !is_hdr) begin
            out_flit_reg <= in_flit;
            out_vld_reg  <= 1'b1;
            if (in_type == TAIL) last_reg <= 1'b1;
          end else if (drain) begin
            out_vld_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign reqi     = reqi_reg;
  assign out_flit = out_flit_reg;
  assign out_vld  = out_vld_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_req_ctl.sv
// Directed bench for req_ctl: a 4-port instance for the packet flows and a 5-port one for range checks.
module tb_req_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       out_rdy = 1'b1;
  logic       err_clr = 1'b0;

  logic [9:0] a_flit = '0;
  logic       a_vld = 1'b0;
  logic       a_rdy;
  logic [3:0] a_reqi;
  logic [3:0] a_gnt = '0;
  logic [9:0] a_oflit;
  logic       a_ovld;
  logic       a_err;

  logic [9:0] b_flit = '0;
  logic       b_vld = 1'b0;
  logic       b_rdy;
  logic [4:0] b_reqi;
  logic [4:0] b_gnt = '0;
  logic [9:0] b_oflit;
  logic       b_ovld;
  logic       b_err;

  int n_cmp = 0;
  int n_mis = 0;
  int beats = 0;
  int b0;

  logic [9:0] h1, bd1, t1, s2, h3, bd3, t3, h4, bd4, t4, h6, h7, junk_h, junk_b;

  always #5 clk = ~clk;

  req_ctl #(.NPORT(4), .FLIT_W(10)) dut_a (
    .clk(clk), .rst(rst), .in_flit(a_flit), .in_vld(a_vld), .in_rdy(a_rdy),
    .reqi(a_reqi), .gnt(a_gnt), .out_flit(a_oflit), .out_vld(a_ovld),
    .out_rdy(out_rdy), .err_clr(err_clr), .err(a_err)
  );

  req_ctl #(.NPORT(5), .FLIT_W(10)) dut_b (
    .clk(clk), .rst(rst), .in_flit(b_flit), .in_vld(b_vld), .in_rdy(b_rdy),
    .reqi(b_reqi), .gnt(b_gnt), .out_flit(b_oflit), .out_vld(b_ovld),
    .out_rdy(out_rdy), .err_clr(err_clr), .err(b_err)
  );

  always @(posedge clk) if (a_ovld && out_rdy) beats <= beats + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] mka(input logic [1:0] t, input logic [5:0] p, input logic [1:0] d);
    return {t, p, d};
  endfunction

  function automatic logic [9:0] mkb(input logic [1:0] t, input logic [4:0] p, input logic [2:0] d);
    return {t, p, d};
  endfunction

  initial begin
    h1  = mka(2'b10, 6'h11, 2'd2);  bd1 = mka(2'b00, 6'h12, 2'd2);  t1 = mka(2'b01, 6'h13, 2'd2);
    s2  = mka(2'b11, 6'h21, 2'd1);
    h3  = mka(2'b10, 6'h31, 2'd3);  bd3 = mka(2'b00, 6'h32, 2'd3);  t3 = mka(2'b01, 6'h33, 2'd3);
    h4  = mka(2'b10, 6'h41, 2'd0);  bd4 = mka(2'b00, 6'h42, 2'd0);  t4 = mka(2'b01, 6'h43, 2'd0);
    h6  = mka(2'b10, 6'h61, 2'd2);  h7  = mka(2'b10, 6'h71, 2'd3);
    junk_h = mka(2'b10, 6'h3f, 2'd1);
    junk_b = mka(2'b00, 6'h2a, 2'd0);

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_reqi", a_reqi, 4'b0000);
    check("rst_ovld", a_ovld, 1'b0);
    check("rst_oflit", a_oflit, 10'h000);
    check("rst_err", a_err, 1'b0);
    check("rst_rdy", a_rdy, 1'b1);

    // Basic packet: head dest=2, grant in cycle 2, body + tail
    tick(); a_vld = 1'b1; a_flit = h1; #1 check("p1_rdy_c0", a_rdy, 1'b1);
    tick(); a_flit = bd1; #1
    check("p1_reqi_c1", a_reqi, 4'b0100);
    check("p1_rdy_c1", a_rdy, 1'b0);
    tick(); a_gnt = 4'b0100; #1
    check("p1_reqi_c2", a_reqi, 4'b0100);
    check("p1_ovld_c2", a_ovld, 1'b0);
    tick(); a_gnt = 4'b0000; #1
    check("p1_head_c3", a_oflit, h1);
    check("p1_ovld_c3", a_ovld, 1'b1);
    check("p1_rdy_c3", a_rdy, 1'b1);
    tick(); a_flit = t1; #1
    check("p1_body_c4", a_oflit, bd1);
    tick(); a_vld = 1'b0; #1
    check("p1_tail_c5", a_oflit, t1);
    check("p1_rdy_c5", a_rdy, 1'b0);
    tick(); #1
    check("p1_reqi_c6", a_reqi, 4'b0000);
    check("p1_ovld_c6", a_ovld, 1'b0);
    check("p1_idle_c6", a_rdy, 1'b1);

    // Single flit dest=1; non-matching grant bits ignored
    b0 = beats;
    tick(); a_vld = 1'b1; a_flit = s2; #1
    tick(); a_vld = 1'b0; a_gnt = 4'b1101; #1
    check("s_reqi", a_reqi, 4'b0010);
    check("s_rdy_req", a_rdy, 1'b0);
    tick(); a_gnt = 4'b0010; #1
    check("s_nogrant", a_ovld, 1'b0);
    tick(); a_gnt = 4'b0000; a_vld = 1'b1; a_flit = junk_b; #1
    check("s_oflit", a_oflit, s2);
    check("s_ovld", a_ovld, 1'b1);
    check("s_rdy_xfer", a_rdy, 1'b0);
    tick(); a_vld = 1'b0; #1
    check("s_ovld_off", a_ovld, 1'b0);
    check("s_reqi_off", a_reqi, 4'b0000);
    check("s_err", a_err, 1'b0);
    check("s_beats", beats - b0, 1);

    // Backpressure: out_rdy low for 3 cycles with the head in the output register
    b0 = beats;
    tick(); a_vld = 1'b1; a_flit = h3; #1
    tick(); a_vld = 1'b0; a_gnt = 4'b1000; #1
    tick(); a_gnt = 4'b0000; out_rdy = 1'b0; a_vld = 1'b1; a_flit = bd3; #1
    check("bp_hold0", a_oflit, h3);
    check("bp_rdy0", a_rdy, 1'b0);
    tick(); #1
    check("bp_hold1", a_oflit, h3);
    check("bp_rdy1", a_rdy, 1'b0);
    tick(); #1
    check("bp_hold2", a_oflit, h3);
    check("bp_rdy2", a_rdy, 1'b0);
    tick(); out_rdy = 1'b1; #1
    check("bp_hold3", a_oflit, h3);
    check("bp_rdy3", a_rdy, 1'b1);
    tick(); a_flit = t3; #1
    check("bp_body", a_oflit, bd3);
    tick(); a_vld = 1'b0; #1
    check("bp_tail", a_oflit, t3);
    tick(); #1
    check("bp_ovld_off", a_ovld, 1'b0);
    check("bp_beats", beats - b0, 3);

    // Protocol errors: body in IDLE, then head in XFER
    tick(); a_vld = 1'b1; a_flit = junk_b; #1
    check("e_rdy_idle", a_rdy, 1'b1);
    tick(); a_vld = 1'b0; #1
    check("e_body_err", a_err, 1'b1);
    check("e_body_reqi", a_reqi, 4'b0000);
    check("e_body_idle", a_rdy, 1'b1);
    tick(); err_clr = 1'b1; #1
    tick(); err_clr = 1'b0; #1
    check("e_clr1", a_err, 1'b0);
    b0 = beats;
    tick(); a_vld = 1'b1; a_flit = h4; #1
    tick(); a_vld = 1'b0; a_gnt = 4'b0001; #1
    tick(); a_gnt = 4'b0000; a_vld = 1'b1; a_flit = junk_h; #1
    check("e_head_out", a_oflit, h4);
    tick(); a_flit = bd4; #1
    check("e_head_err", a_err, 1'b1);
    check("e_head_drop", a_ovld, 1'b0);
    check("e_head_reqi", a_reqi, 4'b0001);
    tick(); a_flit = t4; #1
    check("e_body_out", a_oflit, bd4);
    tick(); a_vld = 1'b0; #1
    check("e_tail_out", a_oflit, t4);
    tick(); err_clr = 1'b1; #1
    check("e_done_reqi", a_reqi, 4'b0000);
    tick(); err_clr = 1'b0; #1
    check("e_clr2", a_err, 1'b0);
    check("e_beats", beats - b0, 3);

    // NPORT=5 range checks: dest 6 and 5 rejected, dest 4 accepted
    tick(); b_vld = 1'b1; b_flit = mkb(2'b10, 5'h03, 3'd6); #1
    check("r6_rdy", b_rdy, 1'b1);
    tick(); b_vld = 1'b0; #1
    check("r6_err", b_err, 1'b1);
    check("r6_reqi", b_reqi, 5'b00000);
    check("r6_idle", b_rdy, 1'b1);
    tick(); b_vld = 1'b1; b_flit = mkb(2'b11, 5'h05, 3'd5); #1
    tick(); b_vld = 1'b0; #1
    check("r5_reqi", b_reqi, 5'b00000);
    tick(); b_vld = 1'b1; b_flit = mkb(2'b10, 5'h04, 3'd4); #1
    tick(); b_vld = 1'b0; #1
    check("r4_reqi", b_reqi, 5'b10000);
    check("r4_rdy", b_rdy, 1'b0);

    // Asynchronous reset in XFER with err set and out_vld high
    tick(); a_vld = 1'b1; a_flit = h6; #1
    tick(); a_vld = 1'b0; a_gnt = 4'b0100; #1
    tick(); a_gnt = 4'b0000; a_vld = 1'b1; a_flit = junk_h; #1
    tick(); out_rdy = 1'b0; a_flit = junk_b; #1
    tick(); a_vld = 1'b0; #1
    check("ar_pre_err", a_err, 1'b1);
    check("ar_pre_ovld", a_ovld, 1'b1);
    check("ar_pre_reqi", a_reqi, 4'b0100);
    #1 rst = 1'b1;
    #1;
    check("ar_reqi", a_reqi, 4'b0000);
    check("ar_ovld", a_ovld, 1'b0);
    check("ar_err", a_err, 1'b0);
    check("ar_rdy", a_rdy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    out_rdy = 1'b1;
    tick(); a_vld = 1'b1; a_flit = h7; #1
    tick(); a_vld = 1'b0; a_gnt = 4'b1000; #1
    check("ar_new_reqi", a_reqi, 4'b1000);
    tick(); a_gnt = 4'b0000; #1
    check("ar_new_head", a_oflit, h7);
    check("ar_new_ovld", a_ovld, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
